// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   - size encodings driven by the core on req_size
//   - controller state and exception cause enums
//   - request legality / alignment predicates
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned SIZE_W = 3;

    localparam logic [SIZE_W-1:0] SZ_B  = 3'b000;
    localparam logic [SIZE_W-1:0] SZ_BU = 3'b001;
    localparam logic [SIZE_W-1:0] SZ_H  = 3'b010;
    localparam logic [SIZE_W-1:0] SZ_HU = 3'b011;
    localparam logic [SIZE_W-1:0] SZ_W  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_ERR
    } state_e;

    typedef enum logic {
        CAUSE_MISALIGN,
        CAUSE_FAULT
    } cause_e;

    // Reserved encodings, or an unsigned size on a store (meaningless for writes).
    function automatic logic size_illegal(input logic [SIZE_W-1:0] size, input logic we);
        logic bad;
        bad = (size > SZ_W);
        if (we && ((size == SZ_BU) || (size == SZ_HU))) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // Halves need addr[0] clear, words need addr[1:0] clear; bytes are always aligned.
    function automatic logic size_misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if ((size == SZ_H) || (size == SZ_HU)) begin
            mis = addr_lo[0];
        end else if (size == SZ_W) begin
            mis = (addr_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Combinational byte-lane logic for a bus access.
//   size_i      access size encoding (signedness ignored)
//   addr_lo_i   byte offset within the word
//   wdata_i     right-justified store data
//   be_c_o      byte enables for the addressed lanes
//   wdata_c_o   store data replicated across all lanes
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic [SIZE_W-1:0] size_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [BE_W-1:0]   be_c_o,
    output logic [DATA_W-1:0] wdata_c_o
);

    // size[2:1] groups b/bu, h/hu and w; replication lets the bus pick any lane.
    always_comb begin
        be_c_o    = 4'b1111;
        wdata_c_o = wdata_i;
        case (size_i[2:1])
            2'b00: begin
                be_c_o    = 4'b0001 << addr_lo_i;
                wdata_c_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_c_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_c_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_c_o    = 4'b1111;
                wdata_c_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between execute stage and single-port data memory.
//   Core side : req_valid/req_ready handshake, req_we, req_size, req_addr, req_wdata
//   Bus side  : mem_req, mem_we, mem_addr (word aligned), mem_be, mem_wdata, mem_ack, mem_rdata
//   Load data : mbr, delayed_addr, size_q with ld_valid pulse
//   Status    : st_done, exc_misalign, exc_fault pulses; busy
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       mbr,
    output logic [ADDR_W-1:0] delayed_addr,
    output logic [2:0]        size_q,
    output logic              ld_valid,
    output logic              st_done,
    output logic              exc_misalign,
    output logic              exc_fault,
    output logic              busy
);

    localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_e              state_q, state_d;
    cause_e              cause_q, cause_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [SIZE_W-1:0]   lat_size_q, lat_size_d;
    logic                lat_we_q, lat_we_d;

    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   mbr_q, mbr_d;
    logic [ADDR_W-1:0]   daddr_q, daddr_d;
    logic [SIZE_W-1:0]   size_out_q, size_out_d;
    logic                ld_valid_q, ld_valid_d;
    logic                st_done_q, st_done_d;
    logic                exc_mis_q, exc_mis_d;
    logic                exc_flt_q, exc_flt_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;

    logic [BE_W-1:0]     be_c;
    logic [DATA_W-1:0]   wdata_c;
    logic                timeout_c;

    // Lane logic works on the incoming request; results are captured on accept.
    lsu_store_align u_store_align (
        .size_i    (req_size),
        .addr_lo_i (req_addr[1:0]),
        .wdata_i   (req_wdata),
        .be_c_o    (be_c),
        .wdata_c_o (wdata_c)
    );

    // Fires on the WAIT_MAX-th ACCESS cycle; a same-cycle ack takes priority below.
    assign timeout_c = (WAIT_MAX != 0) && (32'(cnt_q) == (WAIT_MAX - 32'd1));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        cnt_d       = cnt_q;
        lat_addr_d  = lat_addr_q;
        lat_size_d  = lat_size_q;
        lat_we_d    = lat_we_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        mbr_d       = mbr_q;
        daddr_d     = daddr_q;
        size_out_d  = size_out_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    lat_addr_d = req_addr;
                    lat_size_d = req_size;
                    lat_we_d   = req_we;
                    cnt_d      = '0;
                    if (size_illegal(req_size, req_we)) begin
                        state_d = ST_ERR;
                        cause_d = CAUSE_FAULT;
                    end else if (size_misaligned(req_size, req_addr[1:0])) begin
                        state_d = ST_ERR;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    state_d = ST_RESP;
                    if (!lat_we_q) begin
                        mbr_d      = mem_rdata;
                        daddr_d    = lat_addr_q;
                        size_out_d = lat_size_q;
                    end
                end else if (timeout_c) begin
                    state_d = ST_ERR;
                    cause_d = CAUSE_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Registered outputs are decoded from the next state so they align with it.
        mem_req_d   = (state_d == ST_ACCESS);
        ld_valid_d  = (state_d == ST_RESP) && !lat_we_d;
        st_done_d   = (state_d == ST_RESP) && lat_we_d;
        exc_mis_d   = (state_d == ST_ERR) && (cause_d == CAUSE_MISALIGN);
        exc_flt_d   = (state_d == ST_ERR) && (cause_d == CAUSE_FAULT);
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cause_q     <= CAUSE_MISALIGN;
            cnt_q       <= '0;
            lat_addr_q  <= '0;
            lat_size_q  <= '0;
            lat_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            mbr_q       <= '0;
            daddr_q     <= '0;
            size_out_q  <= '0;
            ld_valid_q  <= 1'b0;
            st_done_q   <= 1'b0;
            exc_mis_q   <= 1'b0;
            exc_flt_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            cnt_q       <= cnt_d;
            lat_addr_q  <= lat_addr_d;
            lat_size_q  <= lat_size_d;
            lat_we_q    <= lat_we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            mbr_q       <= mbr_d;
            daddr_q     <= daddr_d;
            size_out_q  <= size_out_d;
            ld_valid_q  <= ld_valid_d;
            st_done_q   <= st_done_d;
            exc_mis_q   <= exc_mis_d;
            exc_flt_q   <= exc_flt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign mbr          = mbr_q;
    assign delayed_addr = daddr_q;
    assign size_q       = size_out_q;
    assign ld_valid     = ld_valid_q;
    assign st_done      = st_done_q;
    assign exc_misalign = exc_mis_q;
    assign exc_fault    = exc_flt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: table of single transactions plus
// timeout and mid-access reset sequences.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int K_LD  = 0;
    localparam int K_ST  = 1;
    localparam int K_MIS = 2;
    localparam int K_FLT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mbr;
    logic [31:0] delayed_addr;
    logic [2:0]  size_q;
    logic        ld_valid;
    logic        st_done;
    logic        exc_misalign;
    logic        exc_fault;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    lsu_mem_ctrl #(.ADDR_W(32), .WAIT_MAX(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .mbr          (mbr),
        .delayed_addr (delayed_addr),
        .size_q       (size_q),
        .ld_valid     (ld_valid),
        .st_done      (st_done),
        .exc_misalign (exc_misalign),
        .exc_fault    (exc_fault),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        int          kind;
        logic [31:0] e_maddr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_mbr;
        logic [31:0] e_daddr;
        logic [2:0]  e_size;
    } vec_t;

    vec_t vecs[12];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        @(negedge clk);
        chk1({tag, ".ready_in"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (v.kind >= K_MIS) begin
            chk1({tag, ".exc_mis"}, exc_misalign, v.kind == K_MIS);
            chk1({tag, ".exc_flt"}, exc_fault, v.kind == K_FLT);
            chk1({tag, ".noreq"}, mem_req, 1'b0);
            chk1({tag, ".ready_err"}, req_ready, 1'b0);
            @(negedge clk);
            chk1({tag, ".ready_after"}, req_ready, 1'b1);
            chk1({tag, ".exc_clear"}, exc_misalign | exc_fault, 1'b0);
            chk1({tag, ".noreq2"}, mem_req, 1'b0);
        end else begin
            for (int i = 0; i < v.ack_dly; i++) begin
                chk1({tag, ".req_wait"}, mem_req, 1'b1);
                @(negedge clk);
            end
            chk1({tag, ".req"}, mem_req, 1'b1);
            chk1({tag, ".we"}, mem_we, v.we);
            chkw({tag, ".maddr"}, mem_addr, v.e_maddr);
            chkw({tag, ".be"}, 32'(mem_be), 32'(v.e_be));
            chkw({tag, ".mwdata"}, mem_wdata, v.e_wdata);
            chk1({tag, ".busy"}, busy, 1'b1);
            chk1({tag, ".ready_acc"}, req_ready, 1'b0);
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            chk1({tag, ".ld_valid"}, ld_valid, v.kind == K_LD);
            chk1({tag, ".st_done"}, st_done, v.kind == K_ST);
            chk1({tag, ".req_drop"}, mem_req, 1'b0);
            @(negedge clk);
            chk1({tag, ".ready_after"}, req_ready, 1'b1);
            chk1({tag, ".pulse_clear"}, ld_valid | st_done, 1'b0);
        end
        chkw({tag, ".mbr"}, mbr, v.e_mbr);
        chkw({tag, ".daddr"}, delayed_addr, v.e_daddr);
        chkw({tag, ".size_q"}, 32'(size_q), 32'(v.e_size));
    endtask

    initial begin
        int nreq;
        int nflt;
        int nld;
        vec_t v;

        vecs[0]  = '{1'b0, SZ_B,  32'h1003, 32'h0, 32'hA1B2C3D4, 0, K_LD,  32'h1000, 4'b1000, 32'h0,        32'hA1B2C3D4, 32'h1003, SZ_B};
        vecs[1]  = '{1'b1, SZ_H,  32'h2002, 32'h0000BEEF, 32'h0, 0, K_ST,  32'h2000, 4'b1100, 32'hBEEFBEEF, 32'hA1B2C3D4, 32'h1003, SZ_B};
        vecs[2]  = '{1'b0, SZ_W,  32'h3001, 32'h0, 32'h0,        0, K_MIS, 32'h0,    4'b0000, 32'h0,        32'hA1B2C3D4, 32'h1003, SZ_B};
        vecs[3]  = '{1'b1, SZ_W,  32'h300C, 32'h12345678, 32'h0, 3, K_ST,  32'h300C, 4'b1111, 32'h12345678, 32'hA1B2C3D4, 32'h1003, SZ_B};
        vecs[4]  = '{1'b0, SZ_HU, 32'h5006, 32'h0, 32'h11223344, 1, K_LD,  32'h5004, 4'b1100, 32'h0,        32'h11223344, 32'h5006, SZ_HU};
        vecs[5]  = '{1'b1, SZ_HU, 32'h0010, 32'hFFFF, 32'h0,     0, K_FLT, 32'h0,    4'b0000, 32'h0,        32'h11223344, 32'h5006, SZ_HU};
        vecs[6]  = '{1'b0, 3'b111, 32'h0020, 32'h0, 32'h0,       0, K_FLT, 32'h0,    4'b0000, 32'h0,        32'h11223344, 32'h5006, SZ_HU};
        vecs[7]  = '{1'b1, SZ_B,  32'h7001, 32'h000000AB, 32'h0, 0, K_ST,  32'h7000, 4'b0010, 32'hABABABAB, 32'h11223344, 32'h5006, SZ_HU};
        vecs[8]  = '{1'b0, SZ_H,  32'h8001, 32'h0, 32'h0,        0, K_MIS, 32'h0,    4'b0000, 32'h0,        32'h11223344, 32'h5006, SZ_HU};
        vecs[9]  = '{1'b0, SZ_B,  32'h9002, 32'h0, 32'hDEADBEEF, 0, K_LD,  32'h9000, 4'b0100, 32'h0,        32'hDEADBEEF, 32'h9002, SZ_B};
        vecs[10] = '{1'b1, SZ_BU, 32'h9004, 32'h55, 32'h0,       0, K_FLT, 32'h0,    4'b0000, 32'h0,        32'hDEADBEEF, 32'h9002, SZ_B};
        vecs[11] = '{1'b0, SZ_W,  32'hC008, 32'h0, 32'hCAFEF00D, 2, K_LD,  32'hC008, 4'b1111, 32'h0,        32'hCAFEF00D, 32'hC008, SZ_W};

        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst.mem_req", mem_req, 1'b0);
        chkw("rst.mbr", mbr, 32'h0);
        chkw("rst.mem_addr", mem_addr, 32'h0);
        chk1("rst.busy", busy, 1'b0);
        chk1("rst.pulses", ld_valid | st_done | exc_misalign | exc_fault, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: lh with ack withheld
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_H; req_addr = 32'h6002; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        nreq = 0; nflt = 0; nld = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) nreq++;
            if (exc_fault) nflt++;
            if (ld_valid) nld++;
        end
        chkw("to.req_cycles", 32'(nreq), 32'd15);
        chkw("to.fault_pulses", 32'(nflt), 32'd1);
        chkw("to.ld_pulses", 32'(nld), 32'd0);
        chkw("to.mbr_hold", mbr, 32'hCAFEF00D);
        chk1("to.ready", req_ready, 1'b1);

        // Ack on the 15th mem_req cycle wins over the timeout
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_H; req_addr = 32'h6002;
        @(posedge clk);
        #1 req_valid = 1'b0;
        nflt = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (exc_fault) nflt++;
            if (i == 15) begin
                chk1("ack15.req", mem_req, 1'b1);
                mem_ack = 1'b1;
                mem_rdata = 32'h55AA55AA;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        chk1("ack15.ld_valid", ld_valid, 1'b1);
        chk1("ack15.exc_fault", exc_fault, 1'b0);
        chkw("ack15.nofault_before", 32'(nflt), 32'd0);
        chkw("ack15.mbr", mbr, 32'h55AA55AA);
        chkw("ack15.daddr", delayed_addr, 32'h6002);
        chkw("ack15.size_q", 32'(size_q), 32'(SZ_H));

        // Reset in the middle of an access, then a late ack
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'hA000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk1("mid.req_before", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk1("mid.mem_req", mem_req, 1'b0);
        chkw("mid.mem_addr", mem_addr, 32'h0);
        chkw("mid.mem_be", 32'(mem_be), 32'h0);
        chkw("mid.mem_wdata", mem_wdata, 32'h0);
        chkw("mid.mbr", mbr, 32'h0);
        chkw("mid.daddr", delayed_addr, 32'h0);
        chkw("mid.size_q", 32'(size_q), 32'h0);
        chk1("mid.busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h77777777;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        chk1("late.ld_valid", ld_valid, 1'b0);
        chkw("late.mbr", mbr, 32'h0);
        chk1("late.busy", busy, 1'b0);
        chk1("late.mem_req", mem_req, 1'b0);
        chk1("late.ready", req_ready, 1'b1);

        v = '{1'b0, SZ_BU, 32'h4000, 32'h0, 32'h000000FF, 0, K_LD, 32'h4000, 4'b0001, 32'h0, 32'h000000FF, 32'h4000, SZ_BU};
        run_txn(v, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store sequencer between the core's execute stage and the single-port data-memory bus.
- Accepts one load or store request at a time and checks alignment and size encoding.
- Issues a word-aligned bus access with byte enables and lane-replicated store data, then waits for the memory acknowledge.
- For loads, captures read data into the MBR register, together with the delayed address and size. These three values feed the load sign-extension/lane-select unit.
- Bus timeouts and illegal or misaligned requests are reported as one-cycle exception pulses.

Parameters:
- ADDR_W, 32, byte-address width.
- WAIT_MAX, 15, cycles mem_req may stay high without mem_ack before a fault; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  000 b, 001 bu, 010 h, 011 hu, 100 w.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- mem_req  out  1  bus access request.
- mem_we  out  1  bus write strobe.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits zero.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  bus completes the access this cycle.
- mem_rdata  in  32  read data, valid with mem_ack.
- mbr  out  32  captured load word.
- delayed_addr  out  ADDR_W  address of the access that produced mbr.
- size_q  out  3  size of that access.
- ld_valid  out  1  pulse: mbr, delayed_addr and size_q are valid.
- st_done  out  1  pulse: store completed.
- exc_misalign  out  1  pulse: misaligned request.
- exc_fault  out  1  pulse: illegal size or bus timeout.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, any state): state = IDLE. All outputs are 0: mbr, delayed_addr, size_q, mem_addr, mem_be, mem_wdata, all pulses and mem_req. The wait counter is cleared. An in-flight access is abandoned and a late mem_ack is ignored.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE: req_ready = 1.
  - On accept (req_valid & req_ready), latch addr, size, we and wdata.
  - Illegal size goes to ERR with cause fault. Illegal sizes are 101, 110, 111, or a store with 001/011.
  - Misalignment goes to ERR with cause misalign. Misaligned means: half with addr[0] = 1, or word with addr[1:0] != 00.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_req = 1. mem_addr, mem_we, mem_be and mem_wdata stay stable for the whole state.
  - The wait counter increments each cycle without mem_ack.
  - On mem_ack: for a load, mbr <= mem_rdata, delayed_addr <= latched address, size_q <= latched size. Go to RESP.
  - If WAIT_MAX != 0, the counter reaches WAIT_MAX and mem_ack is low: drop mem_req and go to ERR with cause fault.
  - mem_ack in the same cycle as the timeout: mem_ack wins.
- RESP: one cycle. ld_valid = 1 for a load, st_done = 1 for a store. Then go to IDLE.
- ERR: one cycle. Pulse exc_misalign or exc_fault according to the cause. No bus access is made; mbr and delayed_addr are unchanged. Then go to IDLE.
- Minimum latency: accept at cycle T, mem_req at T+1; mem_ack at T+1 gives ld_valid/st_done at T+2. Throughput is one request per 3 cycles minimum.
- Byte enables, for loads and stores:
  - byte: 0001 << addr[1:0].
  - half: 0011 << (2*addr[1]).
  - word: 1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata unchanged.
- Hold rules:
  - mbr, delayed_addr and size_q hold until the next load ack; stores and errors do not modify them.
  - mem_ack outside ACCESS is ignored.
  - req_valid outside IDLE is ignored, because req_ready = 0.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B, SZ_BU, SZ_H, SZ_HU, SZ_W;
  - the state enum;
  - cause enum {CAUSE_MISALIGN, CAUSE_FAULT}.
- Sub-module lsu_store_align: combinational lane logic (size, addr[1:0], wdata) -> (mem_be, mem_wdata). It is shared later by the store buffer.

Test Plan:
1. lb, addr 0x1003, mem_rdata 0xA1B2C3D4, ack at the first ACCESS cycle -> mem_addr 0x1000, mem_be 1000; ld_valid at T+2 with mbr 0xA1B2C3D4, delayed_addr 0x1003, size_q 000.
2. sh, addr 0x2002, wdata 0x0000BEEF -> mem_we 1, mem_be 1100, mem_wdata 0xBEEFBEEF; st_done after ack; mbr unchanged.
3. lw, addr 0x3001 -> exc_misalign pulse one cycle after accept; mem_req never asserted; req_ready back high the following cycle.
4. lh with ack withheld, WAIT_MAX 15 -> mem_req high exactly 15 cycles, then exc_fault pulse, no ld_valid. Repeat with ack on cycle 15: ld_valid, no fault.
5. Store with size 011 -> exc_fault, no bus access. Size 111 load -> exc_fault.
6. Assert rst mid-ACCESS, then ack after reset releases -> all outputs 0, state IDLE, late ack ignored, next lbu, addr 0x4000 completes normally.
